// File: rtl/tick_pkg.sv
// -----------------------------------------------------------------------------
// tick_pkg
//
// Shared definitions for the board timebase tick scheduler.
//   DIV_DEFAULT     default modulus of each divider stage
//   STAGES_DEFAULT  default number of cascaded stages (one tick per stage)
//   state_e         controller state encoding (2 bits)
//   SEL_*           encoding of the rate-select input
// -----------------------------------------------------------------------------
package tick_pkg;

  localparam int DIV_DEFAULT    = 100;
  localparam int STAGES_DEFAULT = 4;

  // Controller states. IDLE holds the counters, RUN counts freely, STEP
  // counts until the latched rate fires once and then returns to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  // Rate select: index of the tick output that drives tick_sel.
  localparam logic [1:0] SEL_1M  = 2'd0;  // 1 MHz
  localparam logic [1:0] SEL_10K = 2'd1;  // 10 kHz
  localparam logic [1:0] SEL_100 = 2'd2;  // 100 Hz
  localparam logic [1:0] SEL_1   = 2'd3;  // 1 Hz

endpackage : tick_pkg

// File: rtl/mod_n_stage.sv
// -----------------------------------------------------------------------------
// mod_n_stage
//
// One modulo-DIV counter stage of the tick divider chain. Counts 0..DIV-1
// while enabled and wraps to 0; a clear forces 0 regardless of enable.
//
// Ports
//   clk_ref  in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   clr      in   synchronous counter clear (takes priority over en)
//   en       in   advance the count this cycle
//   cnt      out  current count, CW bits
//   at_max   out  high while cnt == DIV-1 (the stage will wrap on its next advance)
// -----------------------------------------------------------------------------
module mod_n_stage
  import tick_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int CW  = 7
) (
  input  logic          clk_ref,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  // Only the terminal value is ever compared against; the increment never
  // needs to saturate because the wrap happens exactly at DIV-1.
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == CNT_MAX);
  assign cnt    = cnt_q;

  // NOTE: every path through a combinational block must assign its outputs;
  // the hold value is written first so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_max ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop in
  // the design samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mod_n_stage

// File: rtl/tick_ctrl.sv
// -----------------------------------------------------------------------------
// tick_ctrl
//
// Tick scheduler for the board timebase. A chain of STAGES modulo-DIV
// counters divides clk_ref; stage k produces a one-cycle strobe tick[k] with
// period DIV^(k+1). Downstream logic uses the strobes as clock enables, so
// everything stays in the clk_ref domain. A small controller lets software
// start, stop, single-step and clear the timebase.
//
// Ports
//   clk_ref    in   system clock (100 MHz), rising edge
//   rst        in   synchronous active-high reset
//   start      in   request RUN
//   stop       in   request IDLE (counters held, not cleared)
//   step       in   from IDLE: run until the selected tick fires once
//   clear      in   zero all stage counters; state is unchanged
//   sel[1:0]   in   rate select (see SEL_* in tick_pkg)
//   tick       out  STAGES one-cycle strobes
//   tick_sel   out  tick[sel], using the latched sel while stepping
//   step_done  out  one-cycle pulse when a single step completes
//   running    out  high in RUN or STEP
//
// Input priority: rst > clear > stop > start > step.
// -----------------------------------------------------------------------------
module tick_ctrl
  import tick_pkg::*;
#(
  parameter int DIV    = DIV_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT,
  parameter int CW     = 7
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              clear,
  input  logic [1:0]        sel,
  output logic [STAGES-1:0] tick,
  output logic              tick_sel,
  output logic              step_done,
  output logic              running
);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [STAGES-1:0] tick_q, tick_d;
  logic              step_done_q, step_done_d;

  logic [STAGES-1:0] at_max;
  // carry[k] is high when the controller is counting and stages 0..k-1 are
  // all at DIV-1: it is the enable of stage k. carry[k+1] is therefore the
  // "tick[k] fires at this edge" condition.
  logic [STAGES:0]   carry;
  // The per-stage counts are not consumed here; only at_max matters to the
  // control logic. They stay visible for probing in simulation.
  logic [CW-1:0]     stage_cnt_unused [STAGES];

  logic              sel_fire;
  logic              tick_sel_mux;

  assign running  = (state_q != ST_IDLE);
  assign carry[0] = running;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mod_n_stage #(
      .DIV (DIV),
      .CW  (CW)
    ) u_stage (
      .clk_ref (clk_ref),
      .rst     (rst),
      .clr     (clear),
      .en      (carry[k]),
      .cnt     (stage_cnt_unused[k]),
      .at_max  (at_max[k])
    );
    assign carry[k+1] = carry[k] & at_max[k];
  end

  // Select the fire condition (for step completion) and the registered tick
  // (for tick_sel) by the effective select value held in sel_q.
  always_comb begin
    sel_fire     = 1'b0;
    tick_sel_mux = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (int'(sel_q) == k) begin
        sel_fire     = carry[k+1];
        tick_sel_mux = tick_q[k];
      end
    end
  end

  // Controller next state. A clear freezes the state for that cycle, which
  // also swallows a step completion that would coincide with it.
  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    if (!clear) begin
      unique case (state_q)
        ST_IDLE: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (start) begin
            state_d = ST_RUN;
          end else if (step) begin
            state_d = ST_STEP;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
          end
        end
        ST_STEP: begin
          // stop and start both pre-empt the completion, so neither
          // produces a step_done.
          if (stop) begin
            state_d = ST_IDLE;
          end else if (start) begin
            state_d = ST_RUN;
          end else if (sel_fire) begin
            state_d     = ST_IDLE;
            step_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Tick strobes are the registered fire conditions; a clear drops any that
  // would have been registered on the same edge.
  always_comb begin
    tick_d = clear ? '0 : carry[STAGES:1];
  end

  // sel is live in IDLE and RUN and frozen while stepping. Because the
  // register also loads on the IDLE->STEP edge, it captures the step rate.
  always_comb begin
    sel_d = (state_q == ST_STEP) ? sel_q : sel;
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_1M;
      tick_q      <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      tick_q      <= tick_d;
      step_done_q <= step_done_d;
    end
  end

  assign tick      = tick_q;
  assign tick_sel  = tick_sel_mux;
  assign step_done = step_done_q;

endmodule : tick_ctrl
